// File: rtl/layer_compositor.sv
// ============================================================================
// Module      : layer_compositor
// Description : N-layer priority compositor with a 2-stage pipeline and
//               per-frame A/B collision statistics.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module layer_compositor #(
  parameter int               N_LAYERS = 10,
  parameter int               RGB_W    = 3,
  parameter int               CNT_W    = 8,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          video_on,
  input  logic                          frame_start,
  input  logic [N_LAYERS-1:0]           on_objs,
  input  logic [N_LAYERS*RGB_W-1:0]     rgb_objs,
  input  logic [N_LAYERS-1:0]           layer_en,
  input  logic [N_LAYERS-1:0]           coll_mask_a,
  input  logic [N_LAYERS-1:0]           coll_mask_b,
  output logic [RGB_W-1:0]              rgb,
  output logic                          colision_pix,
  output logic                          colision,
  output logic [CNT_W-1:0]              hit_count,
  output logic [$clog2(N_LAYERS)-1:0]   hit_layer
);

  localparam int c_IDX_W = $clog2(N_LAYERS);

  // Stage 1 registers
  logic [N_LAYERS-1:0]       r_eff;
  logic [N_LAYERS*RGB_W-1:0] r_rgb_objs;
  logic                      r_video_on;
  logic                      r_frame_start;
  logic [N_LAYERS-1:0]       r_mask_a;
  logic [N_LAYERS-1:0]       r_mask_b;

  // Frame accumulators
  logic                      r_acc_hit;
  logic [CNT_W-1:0]          r_acc_cnt;
  logic [c_IDX_W-1:0]        r_acc_layer;

  logic [RGB_W-1:0]          w_top_color;
  logic [N_LAYERS-1:0]       w_hit_b;
  logic [c_IDX_W-1:0]        w_low_idx;
  logic                      w_pix_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_eff         <= '0;
      r_rgb_objs    <= '0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_mask_a      <= '0;
      r_mask_b      <= '0;
    end else begin
      r_eff         <= on_objs & layer_en;
      r_rgb_objs    <= rgb_objs;
      r_video_on    <= video_on;
      r_frame_start <= frame_start;
      r_mask_a      <= coll_mask_a;
      // A layer in both groups belongs to A only, so it cannot hit itself.
      r_mask_b      <= coll_mask_b & ~coll_mask_a;
    end
  end

  // Later (higher-index) layers overwrite earlier ones: highest set bit wins.
  always_comb begin
    w_top_color = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (r_eff[i]) w_top_color = r_rgb_objs[i*RGB_W +: RGB_W];
    end
  end

  assign w_hit_b = r_eff & r_mask_b;

  always_comb begin
    w_low_idx = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (w_hit_b[i]) w_low_idx = i[c_IDX_W-1:0];
    end
  end

  assign w_pix_hit = r_video_on & (|(r_eff & r_mask_a)) & (|w_hit_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb          <= '0;
      colision_pix <= 1'b0;
    end else begin
      if (!r_video_on)    rgb <= '0;
      else if (r_eff == '0) rgb <= BG_COLOR;
      else                rgb <= w_top_color;
      colision_pix <= w_pix_hit;
    end
  end

  // The boundary cycle commits the finished frame and starts the new one with its own pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_hit   <= 1'b0;
      r_acc_cnt   <= '0;
      r_acc_layer <= '0;
      colision    <= 1'b0;
      hit_count   <= '0;
      hit_layer   <= '0;
    end else if (r_frame_start) begin
      colision    <= r_acc_hit;
      hit_count   <= r_acc_cnt;
      hit_layer   <= r_acc_hit ? r_acc_layer : '0;
      r_acc_hit   <= w_pix_hit;
      r_acc_cnt   <= w_pix_hit ? CNT_W'(1) : '0;
      r_acc_layer <= w_pix_hit ? w_low_idx : '0;
    end else if (w_pix_hit) begin
      r_acc_hit <= 1'b1;
      if (r_acc_cnt != {CNT_W{1'b1}}) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      if (!r_acc_hit || (w_low_idx < r_acc_layer)) r_acc_layer <= w_low_idx;
    end
  end

endmodule

`default_nettype wire
